// File: rtl/uart_rx_oversampler.sv
// uart_rx_oversampler
//   UART receiver for 8N1 frames (8E1/8O1 when UART_RX_PARITY_EN is defined).
//   A free-running phase-accumulator NCO produces a 16x (OS_RATE) oversample
//   tick from the system clock; the serial line is synchronised, the start
//   bit is qualified at its midpoint and every following bit is sampled at
//   its midpoint.
//
//   Optional feature macro: UART_RX_PARITY_EN (adds PARITY state, PARITY_ODD
//   parameter and the parity_err port).
//
// Ports
//   clk_in      system clock (24 MHz nominal)
//   rst         synchronous active-high reset
//   rx_in       asynchronous serial line, idle high
//   data_out    last correctly received byte
//   data_valid  one-cycle pulse when data_out updates
//   frame_err   one-cycle pulse on a bad (low) stop bit
//   busy        high while a frame is in progress
//   parity_err  one-cycle pulse with data_valid on parity mismatch (optional)
module uart_rx_oversampler #(
  parameter int ACC_WIDTH = 17,
  parameter int ACC_INC   = 40265,
  parameter int OS_RATE   = 16
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  , output logic     parity_err
`endif
);

  localparam int OSW = $clog2(OS_RATE);
  localparam logic [ACC_WIDTH:0] INC     = ACC_INC[ACC_WIDTH:0];
  localparam logic [OSW-1:0]     OS_MID  = OSW'(OS_RATE / 2 - 1);
  localparam logic [OSW-1:0]     OS_LAST = OSW'(OS_RATE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH:0]     w_sum;
  logic                   w_tick;
  logic [1:0]             r_sync;
  logic                   w_rx_s;
  logic [OSW-1:0]         r_os;
  logic [OSW-1:0]         w_os_nxt;
  logic [2:0]             r_bit;
  logic [2:0]             w_bit_nxt;
  logic [7:0]             r_shift;
  logic                   w_midbit;
  logic                   w_shift_en;
  logic                   w_load;
  logic                   w_ferr;
`ifdef UART_RX_PARITY_EN
  logic                   r_par;
  logic                   w_par_en;
  logic                   w_perr;
`endif

  // The tick is the carry-out of the accumulator add; with ACC_INC below
  // half the modulus it can never be high on two consecutive cycles.
  assign w_sum  = {1'b0, r_acc} + INC;
  assign w_tick = w_sum[ACC_WIDTH];
  assign w_rx_s = r_sync[1];

  // State register and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_acc      <= '0;
      r_sync     <= 2'b11;
      r_os       <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_sum[ACC_WIDTH-1:0];
      r_sync     <= {r_sync[0], rx_in};
      r_os       <= w_os_nxt;
      r_bit      <= w_bit_nxt;
      if (w_shift_en) r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_load)     data_out <= r_shift;
      data_valid <= w_load;
      frame_err  <= w_ferr;
`ifdef UART_RX_PARITY_EN
      if (w_par_en) r_par <= w_rx_s;
      parity_err <= w_perr;
`endif
    end
  end

  // Next-state logic; everything advances only on oversample ticks
  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os;
    w_bit_nxt   = r_bit;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx_s) begin
            w_state_nxt = S_START;
            w_os_nxt    = '0;
          end
        end
        S_START: begin
          if (r_os == OS_MID) begin
            w_os_nxt    = '0;
            w_bit_nxt   = '0;
            w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_os_nxt = r_os + 1'b1;
          end
        end
        S_DATA: begin
          w_os_nxt = r_os + 1'b1;
          if (r_os == OS_LAST) begin
            w_bit_nxt = r_bit + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (r_bit == 3'd7) w_state_nxt = S_PARITY;
`else
            if (r_bit == 3'd7) w_state_nxt = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          w_os_nxt = r_os + 1'b1;
          if (r_os == OS_LAST) w_state_nxt = S_STOP;
        end
`endif
        S_STOP: begin
          w_os_nxt = r_os + 1'b1;
          // Returning to IDLE at mid stop bit lets a back-to-back start edge
          // be caught without any idle gap.
          if (r_os == OS_LAST) w_state_nxt = w_rx_s ? S_IDLE : S_BREAK;
        end
        S_BREAK: begin
          if (w_rx_s) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output / strobe decode
  always_comb begin
    w_midbit   = w_tick && (r_os == OS_LAST);
    w_shift_en = w_midbit && (r_state == S_DATA);
    w_load     = w_midbit && (r_state == S_STOP) && w_rx_s;
    w_ferr     = w_midbit && (r_state == S_STOP) && !w_rx_s;
    busy       = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    w_par_en   = w_midbit && (r_state == S_PARITY);
    // XOR of data and parity bit is 0 for even parity, 1 for odd.
    w_perr     = w_load && ((^r_shift ^ r_par) != PARITY_ODD);
`endif
  end

endmodule

// File: tb/tb_uart_rx_oversampler.sv
module tb_uart_rx_oversampler;

`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int SLOW_BIT = 256;
  localparam int DEF_BIT  = 52;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_s_line = 1'b1;
  logic       rx_d_line = 1'b1;
  logic [7:0] dout_s, dout_d;
  logic       dv_s, dv_d, fe_s, fe_d, busy_s, busy_d;
`ifdef UART_RX_PARITY_EN
  logic       perr_s, perr_d;
`endif

  always #5 clk = ~clk;

  uart_rx_oversampler #(.ACC_WIDTH(17), .ACC_INC(8192), .OS_RATE(16)) dut_slow (
    .clk_in(clk), .rst(rst), .rx_in(rx_s_line),
    .data_out(dout_s), .data_valid(dv_s), .frame_err(fe_s), .busy(busy_s)
`ifdef UART_RX_PARITY_EN
    , .parity_err(perr_s)
`endif
  );

  uart_rx_oversampler dut_def (
    .clk_in(clk), .rst(rst), .rx_in(rx_d_line),
    .data_out(dout_d), .data_valid(dv_d), .frame_err(fe_d), .busy(busy_d)
`ifdef UART_RX_PARITY_EN
    , .parity_err(perr_d)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle counter and output monitors (sampled on the falling edge)
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_dv_s = 0, n_fe_s = 0, n_busy_s = 0, n_both = 0;
  int dv_cyc_s = 0, busy_fall_s = 0;
  logic busy_prev_s = 1'b0;
  int n_dv_d = 0, n_fe_d = 0;
  logic [7:0] dcap [0:7];
`ifdef UART_RX_PARITY_EN
  int n_perr_s = 0, n_perr_nodv = 0;
`endif

  always @(negedge clk) begin
    if (!rst) begin
      if (dv_s) begin n_dv_s++; dv_cyc_s = cyc; end
      if (fe_s) n_fe_s++;
      if (busy_s) n_busy_s++;
      if (busy_prev_s && !busy_s) busy_fall_s = cyc;
      if ((dv_s && fe_s) || (dv_d && fe_d)) n_both++;
      if (dv_d) begin dcap[n_dv_d % 8] = dout_d; n_dv_d++; end
      if (fe_d) n_fe_d++;
`ifdef UART_RX_PARITY_EN
      if (perr_s) n_perr_s++;
      if ((perr_s && !dv_s) || (perr_d && !dv_d)) n_perr_nodv++;
`endif
    end
    busy_prev_s = busy_s;
  end

  task automatic drive_bit(input int which, input logic v, input int n);
    if (which == 0) rx_s_line = v;
    else            rx_d_line = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic stop,
                            input logic par_flip, input int bitclk);
    drive_bit(which, 1'b0, bitclk);
    for (int i = 0; i < 8; i++) drive_bit(which, b[i], bitclk);
`ifdef UART_RX_PARITY_EN
    drive_bit(which, (^b) ^ par_flip, bitclk);
`else
    if (par_flip) $display("note: no parity bit in 8N1 build");
`endif
    drive_bit(which, stop, bitclk);
    drive_bit(which, 1'b1, 0);
  endtask

  int b_dv, b_fe, b_busy, b_dvd, b_fed, edge_c, lat;

  initial begin
    // Reset and idle line
    repeat (5) @(negedge clk);
    check_val("rst_data_out", dout_s, 8'h00);
    check_val("rst_busy", busy_s, 1'b0);
    check_val("rst_dv_fe", {dv_s, fe_s}, 2'b00);
    rst = 1'b0;
    repeat (2000) @(negedge clk);
    check_val("idle_dv", n_dv_s, 0);
    check_val("idle_fe", n_fe_s, 0);
    check_val("idle_busy", n_busy_s, 0);
    check_val("idle_data_out", dout_s, 8'h00);

    // Single byte 0xA5 at 256-clock bits
    b_dv = n_dv_s; b_fe = n_fe_s;
    edge_c = cyc;
    send_frame(0, 8'hA5, 1'b1, 1'b0, SLOW_BIT);
    repeat (300) @(negedge clk);
    check_val("a5_dv_count", n_dv_s - b_dv, 1);
    check_val("a5_fe_count", n_fe_s - b_fe, 0);
    check_val("a5_data", dout_s, 8'hA5);
    lat = dv_cyc_s - edge_c;
    check_val("a5_latency_ok", (lat >= 2410 + PBITS*SLOW_BIT) && (lat <= 2470 + PBITS*SLOW_BIT), 1'b1);
    lat = busy_fall_s - edge_c;
    check_val("a5_busy_fall_ok", (lat >= 2410 + PBITS*SLOW_BIT) && (lat <= 2470 + PBITS*SLOW_BIT), 1'b1);

    // Start-bit glitch: 64 clocks low
    b_dv = n_dv_s; b_fe = n_fe_s; b_busy = n_busy_s;
    drive_bit(0, 1'b0, 64);
    drive_bit(0, 1'b1, 400);
    check_val("glitch_busy_seen", (n_busy_s - b_busy) > 0, 1'b1);
    check_val("glitch_dv", n_dv_s - b_dv, 0);
    check_val("glitch_fe", n_fe_s - b_fe, 0);
    check_val("glitch_idle", busy_s, 1'b0);

    // Framing error: 0x3C with a low stop bit, then line high
    b_dv = n_dv_s; b_fe = n_fe_s;
    send_frame(0, 8'h3C, 1'b0, 1'b0, SLOW_BIT);
    repeat (600) @(negedge clk);
    check_val("ferr_count", n_fe_s - b_fe, 1);
    check_val("ferr_dv", n_dv_s - b_dv, 0);
    check_val("ferr_data_kept", dout_s, 8'hA5);
    check_val("ferr_idle", busy_s, 1'b0);

    // Break: line held low 5000 clocks
    b_dv = n_dv_s; b_fe = n_fe_s;
    drive_bit(0, 1'b0, 5000);
    check_val("break_busy", busy_s, 1'b1);
    drive_bit(0, 1'b1, 600);
    check_val("break_fe_once", n_fe_s - b_fe, 1);
    check_val("break_dv", n_dv_s - b_dv, 0);
    check_val("break_data_kept", dout_s, 8'hA5);
    check_val("break_idle", busy_s, 1'b0);

    // Reset during bit 4 of 0x55
    drive_bit(0, 1'b0, SLOW_BIT);
    drive_bit(0, 1'b1, SLOW_BIT);
    drive_bit(0, 1'b0, SLOW_BIT);
    drive_bit(0, 1'b1, SLOW_BIT);
    drive_bit(0, 1'b0, SLOW_BIT);
    drive_bit(0, 1'b1, SLOW_BIT/2);
    check_val("pre_rst_busy", busy_s, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_data_out", dout_s, 8'h00);
    check_val("midrst_busy", busy_s, 1'b0);
    check_val("midrst_dv_fe", {dv_s, fe_s}, 2'b00);
    rst = 1'b0;
    b_dv = n_dv_s; b_fe = n_fe_s;
    drive_bit(0, 1'b1, 3000);
    check_val("midrst_no_pulse", (n_dv_s - b_dv) + (n_fe_s - b_fe), 0);
    send_frame(0, 8'h81, 1'b1, 1'b0, SLOW_BIT);
    repeat (300) @(negedge clk);
    check_val("post_rst_dv", n_dv_s - b_dv, 1);
    check_val("post_rst_data", dout_s, 8'h81);

    // Default rate, back-to-back 0x00 then 0xFF with 52-clock bits
    b_dvd = n_dv_d; b_fed = n_fe_d;
    send_frame(1, 8'h00, 1'b1, 1'b0, DEF_BIT);
    send_frame(1, 8'hFF, 1'b1, 1'b0, DEF_BIT);
    repeat (200) @(negedge clk);
    check_val("b2b_dv_count", n_dv_d - b_dvd, 2);
    check_val("b2b_first", dcap[b_dvd % 8], 8'h00);
    check_val("b2b_second", dcap[(b_dvd + 1) % 8], 8'hFF);
    check_val("b2b_data_out", dout_d, 8'hFF);
    check_val("b2b_fe", n_fe_d - b_fed, 0);
    check_val("b2b_idle", busy_d, 1'b0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1; send 0 instead
    b_dv = n_dv_s; b_busy = n_perr_s;
    send_frame(0, 8'h07, 1'b1, 1'b1, SLOW_BIT);
    repeat (300) @(negedge clk);
    check_val("par_dv", n_dv_s - b_dv, 1);
    check_val("par_err", n_perr_s - b_busy, 1);
    check_val("par_data", dout_s, 8'h07);
    check_val("par_err_with_dv", n_perr_nodv, 0);
`endif

    check_val("dv_fe_exclusive", n_both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampler.md
Name: uart_rx_oversampler

Overview:
- UART receiver: 8N1 frames (optional parity) from the serial line rx_in, deserialised into bytes.
- Built-in phase-accumulator NCO makes a 16x-oversample tick from the 24 MHz system clock. Defaults give 460800 baud x16.
- Receive-side counterpart to the existing transmitter and baud generator; feeds a byte sink via single-cycle valid pulses.

Parameters:
- ACC_WIDTH, 17, NCO accumulator width in bits.
- ACC_INC, 40265, NCO increment; tick rate = f_clk*ACC_INC/2^ACC_WIDTH (24 MHz -> ~7.3728 MHz = 16x460800).
- OS_RATE, 16, oversample ticks per bit; must be a power of two >= 8.

Ports:
- clk_in  input  1  system clock (24 MHz)
- rst  input  1  synchronous active-high reset
- rx_in  input  1  asynchronous serial line, idle high
- data_out  output  8  last correctly received byte
- data_valid  output  1  one clk_in-cycle pulse when data_out updates
- frame_err  output  1  one clk_in-cycle pulse on bad stop bit
- busy  output  1  high while a frame is in progress (any state but IDLE)
- parity_err  output  1  present only with UART_RX_PARITY_EN

Behaviour:
- Reset (synchronous, rst=1 at posedge clk_in):
  - acc=0; synchroniser FFs=1; state=IDLE; os_cnt=0; bit_cnt=0; shift=0.
  - data_out=0x00; data_valid=0; frame_err=0; busy=0; parity_err=0.
  - Reset mid-frame aborts the frame with no pulse.
- NCO: acc <= acc+ACC_INC every cycle, free-running, modulo 2^ACC_WIDTH. tick = carry-out of that add: a 1-cycle pulse, never two consecutive cycles.
- rx_in passes through a 2-FF synchroniser (rx_s). All sampling uses rx_s and happens only on tick cycles.
- IDLE: on tick with rx_s=0 -> START, os_cnt=0.
- START: each tick os_cnt++. On the tick where os_cnt==OS_RATE/2-1 (mid start bit):
  - rx_s=0 -> DATA, os_cnt=0, bit_cnt=0.
  - rx_s=1 -> glitch, back to IDLE, no pulses.
- DATA: each tick os_cnt++ (wraps at OS_RATE). On the tick with os_cnt==OS_RATE-1 (mid-bit):
  - shift <= {rx_s, shift[7:1]} (LSB first); bit_cnt++.
  - After bit 7 -> STOP (or PARITY when enabled).
- STOP: on the tick with os_cnt==OS_RATE-1:
  - rx_s=1 -> data_out<=shift, data_valid=1 for exactly one clk_in cycle, -> IDLE.
  - rx_s=0 -> frame_err=1 for one cycle, data_out unchanged, no data_valid, -> BREAK.
- BREAK: stay until a tick with rx_s=1, then -> IDLE. A held-low line (break) gives exactly one frame_err and no spurious frames.
- data_valid and frame_err are never high together. Both are registered outputs.
- Back-to-back frames: IDLE is re-entered at mid stop bit, so the next start edge is caught with no gap needed.

Optional Feature:
- Macro UART_RX_PARITY_EN; parity type selected by parameter PARITY_ODD (default 0 = even).
- Defined:
  - PARITY state follows the 8th data bit and samples one bit at mid-bit.
  - Mismatch -> parity_err pulses one cycle together with data_valid at the stop bit. The byte is still delivered.
  - A frame error overrides: frame_err pulses, parity_err stays 0.
- Undefined: no PARITY state, no parity_err port; pure 8N1.

Test Plan:
- Idle/reset: rst 5 cycles, rx_in=1 for 2000 cycles -> data_out=0x00, data_valid/frame_err/busy never 1.
- Single byte, ACC_INC=8192 (tick every 16 clocks, bit=256 clocks): send 0xA5 8N1 -> exactly one data_valid, data_out=0xA5, pulse 2410-2470 clocks after start edge, busy drops in same window.
- Glitch: rx_in low 64 clocks then high (ACC_INC=8192) -> busy pulses briefly, no data_valid, no frame_err, back to IDLE.
- Framing: send 0x3C with stop bit 0, line then high -> one frame_err, no data_valid, data_out keeps 0xA5. Hold line low 5000 clocks -> still only one frame_err.
- Default rate back-to-back: 52-clock bits, 0x00 then 0xFF, no idle gap -> two data_valid pulses, data_out 0x00 then 0xFF.
- Reset mid-frame: assert rst during bit 4 of 0x55 -> next cycle all outputs 0, no pulses. Following 0x81 is received correctly. With UART_RX_PARITY_EN (even): 0x07 with parity bit 0 -> data_valid with parity_err=1.
